// File: rtl/output_pkg.sv
// Shared state type and C-matrix geometry helpers for the output buffer/streamer
// and the compute unit's write-address generator.
package output_pkg;

  typedef enum logic {COLLECT, STREAM} out_state_t;

  localparam int unsigned DefOutw = 24;
  localparam int unsigned DefM    = 7;
  localparam int unsigned DefN    = 9;

  function automatic int unsigned c_elems(int unsigned m, int unsigned n);
    return m * n;
  endfunction

  function automatic int unsigned c_addr_bits(int unsigned m, int unsigned n);
    return (m * n > 1) ? $clog2(m * n) : 1;
  endfunction

endpackage

// File: rtl/output_mems_if.sv
// Compute-side write port plus AXI-Stream output of the C buffer.
// AXIS_TLAST exists only when OUTPUT_TLAST_EN is defined.
interface output_mems_if
  import output_pkg::*;
#(
  parameter int unsigned OUTW = DefOutw,
  parameter int unsigned M    = DefM,
  parameter int unsigned N    = DefN
) ();

  localparam int unsigned C_ADDR_BITS = c_addr_bits(M, N);

  logic                   C_wr_en;
  logic [C_ADDR_BITS-1:0] C_wr_addr;
  logic signed [OUTW-1:0] C_wr_data;
  logic                   compute_done;
  logic                   out_buf_free;
  logic [OUTW-1:0]        AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic                   AXIS_TREADY;

  // master: the buffer/streamer (AXIS master); slave: compute unit plus stream sink.
`ifdef OUTPUT_TLAST_EN
  logic                   AXIS_TLAST;

  modport master (
    input  C_wr_en, C_wr_addr, C_wr_data, compute_done, AXIS_TREADY,
    output out_buf_free, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST
  );
  modport slave (
    output C_wr_en, C_wr_addr, C_wr_data, compute_done, AXIS_TREADY,
    input  out_buf_free, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST
  );
`else
  modport master (
    input  C_wr_en, C_wr_addr, C_wr_data, compute_done, AXIS_TREADY,
    output out_buf_free, AXIS_TDATA, AXIS_TVALID
  );
  modport slave (
    output C_wr_en, C_wr_addr, C_wr_data, compute_done, AXIS_TREADY,
    input  out_buf_free, AXIS_TDATA, AXIS_TVALID
  );
`endif

endinterface

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO whose head register directly drives the AXI-Stream outputs,
// so TDATA/TVALID are always registered.
module axis_skid_fifo #(
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [Width-1:0] head_q, tail_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= din;
          end else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head_q;
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/sp_ram.sv
// Single-port RAM with one-cycle synchronous read; contents are never reset.
module sp_ram #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 63,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/output_mems.sv
// Buffers the MxN result matrix C, then streams it row-major over AXI-Stream.
// Define OUTPUT_TLAST_EN to add AXIS_TLAST on the final element.
module output_mems
  import output_pkg::*;
#(
  parameter int unsigned OUTW = DefOutw,
  parameter int unsigned M    = DefM,
  parameter int unsigned N    = DefN
) (
  input  logic          clk,
  input  logic          reset,
  output_mems_if.master bus
);

  localparam int unsigned Elems = c_elems(M, N);
  localparam int unsigned AddrW = c_addr_bits(M, N);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Elems - 1);
`ifdef OUTPUT_TLAST_EN
  localparam int unsigned FifoW = OUTW + 1;
`else
  localparam int unsigned FifoW = OUTW;
`endif

  out_state_t       state_q;
  logic             buf_free_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic             issued_all_q;
  logic             inflight_q;
  logic [OUTW-1:0]  rd_data;
  logic [AddrW-1:0] mem_addr;
  logic             mem_we;
  logic [FifoW-1:0] fifo_din, fifo_dout;
  logic [1:0]       fifo_count;
  logic             fifo_valid;
  logic             pop, rd_en, last_pop;
  logic [2:0]       occupancy;

  always_comb begin
    pop = fifo_valid & bus.AXIS_TREADY;
    // Credit the pop happening this cycle so a full-rate stream never bubbles.
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en     = (state_q == STREAM) && !issued_all_q && (occupancy < 3'd2);
    last_pop  = pop && issued_all_q && !inflight_q && (fifo_count == 2'd1);
    mem_we    = (state_q == COLLECT) && bus.C_wr_en;
    mem_addr  = (state_q == COLLECT) ? bus.C_wr_addr : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      buf_free_q   <= 1'b1;
      rd_ptr_q     <= '0;
      issued_all_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      unique case (state_q)
        COLLECT: begin
          if (bus.compute_done) begin
            state_q    <= STREAM;
            buf_free_q <= 1'b0;
          end
        end
        STREAM: begin
          if (rd_en) begin
            if (rd_ptr_q == LastAddr) issued_all_q <= 1'b1;
            else                      rd_ptr_q     <= rd_ptr_q + 1'b1;
          end
          if (last_pop) begin
            state_q      <= COLLECT;
            buf_free_q   <= 1'b1;
            rd_ptr_q     <= '0;
            issued_all_q <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  sp_ram #(
    .Width (OUTW),
    .Depth (Elems),
    .AddrW (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.C_wr_data),
    .rdata (rd_data)
  );

`ifdef OUTPUT_TLAST_EN
  logic rd_last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_last_q <= 1'b0;
    else       rd_last_q <= rd_en && (rd_ptr_q == LastAddr);
  end

  assign fifo_din       = {rd_last_q, rd_data};
  assign bus.AXIS_TLAST = fifo_dout[OUTW];
`else
  assign fifo_din = rd_data;
`endif

  axis_skid_fifo #(
    .Width (FifoW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.AXIS_TDATA   = fifo_dout[OUTW-1:0];
  assign bus.AXIS_TVALID  = fifo_valid;
  assign bus.out_buf_free = buf_free_q;

endmodule

// File: doc/output_mems.md
Name: output_mems

Overview:
- Transmit-side counterpart of the matrix input stage.
- Buffers the M×N result matrix C written by the compute unit into an internal single-port memory.
- Once the compute unit signals completion, streams C out row-major as an AXI-Stream master.
- Blocks new compute writes until the whole matrix has been transmitted.

Parameters:
- OUTW, 24, width of one C element and of AXIS_TDATA.
- M, 7, rows of C.
- N, 9, columns of C.
- localparam C_ADDR_BITS = $clog2(M*N), width of the C write address.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- C_wr_en  input  1  compute-side write strobe.
- C_wr_addr  input  C_ADDR_BITS  write address; element (r,c) lives at r*N+c.
- C_wr_data  input  OUTW (signed)  result element.
- compute_done  input  1  single-cycle pulse: C is complete.
- out_buf_free  output  1  high = compute may write C; low = buffer owned by the streamer.
- AXIS_TDATA  output  OUTW  streamed element.
- AXIS_TVALID  output  1  master valid.
- AXIS_TREADY  input  1  slave ready.
- AXIS_TLAST  output  1  present only with OUTPUT_TLAST_EN.

Behaviour:
- Reset (async, active-high):
  - State COLLECT; out_buf_free=1; AXIS_TVALID=0; AXIS_TLAST=0; AXIS_TDATA=0.
  - Read pointer 0; skid buffer empty.
  - Memory contents are not cleared.
- Storage: memory of depth M*N, 1-cycle synchronous read, write-first not required.
- COLLECT state:
  - C_wr_en writes C_wr_data at C_wr_addr.
  - compute_done sampled high moves to STREAM next cycle and drops out_buf_free that same edge.
  - A write and compute_done in the same cycle: the write is committed.
- STREAM state:
  - C_wr_en is ignored.
  - compute_done is ignored.
  - Read pointer rd_ptr issues memory reads 0..M*N-1 in order.
  - Data lands in a 2-entry skid FIFO that drives AXIS_TDATA/TVALID from its head register.
  - A read is issued only when FIFO occupancy + reads in flight < 2. This guarantees no overflow under back-pressure.
- Latency and throughput:
  - compute_done at edge T → first AXIS_TVALID=1 after edge T+2.
  - With TREADY held high, one element is transferred per cycle; 63 elements in 63 consecutive cycles at defaults.
- AXIS rules:
  - Transfer occurs when TVALID && TREADY at a rising edge.
  - Once TVALID is high, it stays high and TDATA stays stable until the transfer.
  - TVALID never depends combinationally on TREADY.
- End of stream:
  - Transfer of element M*N-1 sets state COLLECT, out_buf_free=1, AXIS_TVALID=0 on the next cycle.
  - rd_ptr returns to 0.
  - No wrap beyond M*N-1; rd_ptr saturates until the final transfer.
- Reset mid-stream: the stream is aborted immediately; TVALID drops asynchronously; the next stream starts only after a new compute_done.
- TREADY toggling every cycle: each element is sent exactly once, in order, with no duplicates or drops.

Optional Feature:
- Macro OUTPUT_TLAST_EN.
- Defined:
  - AXIS_TLAST port exists.
  - AXIS_TLAST=1 exactly with the element at address M*N-1, registered alongside TDATA in the skid FIFO.
  - AXIS_TLAST=0 otherwise, including after reset.
- Undefined: no AXIS_TLAST port or logic; the downstream counts M*N elements.

Decomposition:
- Package output_pkg:
  - typedef enum {COLLECT, STREAM} out_state_t.
  - Constant/function computing M*N and address width, shared with the compute unit's write-address generator.
- Reuse the existing memory module for C storage.
- One natural sub-module: axis_skid_fifo (2-entry, OUTW(+1 for TLAST) wide, push/pop/count).

Test Plan:
- Write C[i]=i+100 for i=0..62, pulse compute_done, TREADY=1 → TVALID first high 2 cycles later; TDATA 100..162 on 63 consecutive cycles; out_buf_free returns 1 the cycle after the last transfer.
- Same data, TREADY pattern 1,0,0,1 repeating → exactly 63 transfers in order 100..162; TDATA stable during every stall; no TVALID drop before transfer.
- In STREAM, drive C_wr_en with addr 5, data -1, and a second compute_done → stream unaffected; element 5 still 105; no restart after completion.
- Assert reset when 20 of 63 elements have transferred → TVALID=0 immediately, out_buf_free=1; a new compute_done replays from element 0 (value 100).
- Negative values: C[0]=-8388608, C[62]=8388607 at OUTW=24 → exact bit patterns 0x800000 / 0x7FFFFF on TDATA.
- OUTPUT_TLAST_EN defined → TLAST=1 only on the transfer carrying 162; TLAST=0 elsewhere.
